vdp18_vram_seq: RTL and testbench

VRAM access sequencer at the responding end of the access-slot protocol issued by the timing controller. On every access-slot strobe it executes one VRAM cycle of the announced type:
- Display fetch slots (PNT/PCT/PGT/STST/SAT*/SPT*) read from the display address.
- AC_CPU slots service one latched CPU read or write request.
- Results go back to the pattern/sprite engines and to the CPU port.
The block sits between the timing controller, the address mux and the external VRAM.

---
 rtl/vdp18_pack.sv | 36 +++
 rtl/vdp18_cpu_req_latch.sv | 35 +++
 rtl/vdp18_vram_seq.sv | 126 ++++++++++++
 tb/tb_vdp18_vram_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp18_pack.sv
// Shared VDP types: VRAM slot codes, sequencer states and constants.
// Slot codes are produced by the timing controller, one per access-slot strobe.
package vdp18_pack;

    localparam int vdp_vram_aw_c = 14;

    typedef enum logic [3:0] {
        AC_NONE,
        AC_PNT,
        AC_PCT,
        AC_PGT,
        AC_STST,
        AC_SATY,
        AC_SATX,
        AC_SATN,
        AC_SATC,
        AC_SPTH,
        AC_SPTL,
        AC_CPU
    } access_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } vram_seq_state_t;

    // Kind of VRAM cycle currently owned by the sequencer
    typedef enum logic [1:0] {
        OP_DISP,
        OP_CPU_RD,
        OP_CPU_WR
    } vram_op_t;

endpackage

// File: rtl/vdp18_cpu_req_latch.sv
// Holds one CPU VRAM request until the sequencer retires it; write wins a tie.
// Requests arriving while busy are dropped; busy clears the cycle after release.
module vdp18_cpu_req_latch #(
    parameter int AW = 14
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          wr_req_i,
    input  logic          rd_req_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    input  logic          release_i,
    output logic          busy_o,
    output logic [AW-1:0] addr_o,
    output logic [7:0]    wdata_o,
    output logic          we_o
);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_o  <= 1'b0;
            addr_o  <= '0;
            wdata_o <= '0;
            we_o    <= 1'b0;
        end else if (release_i) begin
            busy_o <= 1'b0;
        end else if (!busy_o && (wr_req_i || rd_req_i)) begin
            busy_o  <= 1'b1;
            addr_o  <= addr_i;
            wdata_o <= wdata_i;
            we_o    <= wr_req_i;
        end
    end

endmodule

// File: rtl/vdp18_vram_seq.sv
// VRAM access sequencer: runs one display or CPU VRAM cycle per access-slot strobe.
// Read result RD_LAT+2 clk_i after the strobe, write done 2 clk_i after; strobes while busy are ignored.
module vdp18_vram_seq
    import vdp18_pack::*;
#(
    parameter int RD_LAT = 2,
    parameter int AW     = vdp_vram_aw_c
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clk_en_acc_i,
    input  access_t       access_type_i,
    input  logic [AW-1:0] disp_addr_i,
    input  logic          cpu_wr_req_i,
    input  logic          cpu_rd_req_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [7:0]    cpu_wdata_i,
    output logic          cpu_busy_o,
    output logic          cpu_done_o,
    output logic [7:0]    cpu_rdata_o,
    output logic [AW-1:0] vram_a_o,
    output logic          vram_ce_o,
    output logic          vram_we_o,
    output logic [7:0]    vram_d_o,
    input  logic [7:0]    vram_d_i,
    output logic [7:0]    disp_data_o,
    output logic          disp_valid_o,
    output access_t       disp_type_o
);

    localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

    vram_seq_state_t state_q, state_d;
    vram_op_t        op_q, start_op;
    logic [2:0]      cnt_q;
    logic            start, op_done;

    logic [AW-1:0]   req_addr;
    logic [7:0]      req_wdata;
    logic            req_we;
    logic            req_release;

    assign req_release = (state_q == DONE) && (op_q != OP_DISP);

    vdp18_cpu_req_latch #(.AW(AW)) u_req (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wr_req_i  (cpu_wr_req_i),
        .rd_req_i  (cpu_rd_req_i),
        .addr_i    (cpu_addr_i),
        .wdata_i   (cpu_wdata_i),
        .release_i (req_release),
        .busy_o    (cpu_busy_o),
        .addr_o    (req_addr),
        .wdata_o   (req_wdata),
        .we_o      (req_we)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Only a request already latched when the strobe arrives may take an AC_CPU slot
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        start_op = OP_DISP;
        case (state_q)
            IDLE: begin
                if (clk_en_acc_i) begin
                    if (access_type_i == AC_CPU) begin
                        if (cpu_busy_o) begin
                            start    = 1'b1;
                            start_op = req_we ? OP_CPU_WR : OP_CPU_RD;
                        end
                    end else if (access_type_i != AC_NONE) begin
                        start = 1'b1;
                    end
                end
                if (start) state_d = ISSUE;
            end
            ISSUE:   state_d = (op_q == OP_CPU_WR) ? DONE : WAIT;
            WAIT:    if (cnt_q == 3'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        op_done = ((state_q == ISSUE) && (op_q == OP_CPU_WR)) ||
                  ((state_q == WAIT) && (cnt_q == 3'd0));
    end

    // Result registers load on entry to DONE, so the pulses coincide with DONE
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            op_q         <= OP_DISP;
            cnt_q        <= '0;
            vram_a_o     <= '0;
            vram_ce_o    <= 1'b0;
            vram_we_o    <= 1'b0;
            vram_d_o     <= '0;
            disp_data_o  <= '0;
            disp_valid_o <= 1'b0;
            disp_type_o  <= AC_NONE;
            cpu_done_o   <= 1'b0;
            cpu_rdata_o  <= '0;
        end else begin
            vram_ce_o    <= start;
            vram_we_o    <= start && (start_op == OP_CPU_WR);
            disp_valid_o <= op_done && (op_q == OP_DISP);
            cpu_done_o   <= op_done && (op_q != OP_DISP);
            if (start) begin
                op_q     <= start_op;
                vram_a_o <= (start_op == OP_DISP) ? disp_addr_i : req_addr;
                if (start_op == OP_CPU_WR) vram_d_o    <= req_wdata;
                if (start_op == OP_DISP)   disp_type_o <= access_type_i;
            end
            if (state_q == ISSUE)
                cnt_q <= CNT_LOAD;
            else if (state_q == WAIT && cnt_q != 3'd0)
                cnt_q <= cnt_q - 3'd1;
            if (op_done && op_q == OP_DISP)   disp_data_o <= vram_d_i;
            if (op_done && op_q == OP_CPU_RD) cpu_rdata_o <= vram_d_i;
        end
    end

endmodule

// File: tb/tb_vdp18_vram_seq.sv
// Directed bench for vdp18_vram_seq with a fixed-latency VRAM model.
module tb_vdp18_vram_seq;
    import vdp18_pack::*;

    localparam int RD_LAT = 2;
    localparam int AW     = 14;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          clk_en_acc_i;
    access_t       access_type_i;
    logic [AW-1:0] disp_addr_i;
    logic          cpu_wr_req_i;
    logic          cpu_rd_req_i;
    logic [AW-1:0] cpu_addr_i;
    logic [7:0]    cpu_wdata_i;
    logic          cpu_busy_o;
    logic          cpu_done_o;
    logic [7:0]    cpu_rdata_o;
    logic [AW-1:0] vram_a_o;
    logic          vram_ce_o;
    logic          vram_we_o;
    logic [7:0]    vram_d_o;
    logic [7:0]    vram_d_i;
    logic [7:0]    disp_data_o;
    logic          disp_valid_o;
    access_t       disp_type_o;

    int checks = 0;
    int errors = 0;
    int ce_cnt = 0;
    int done_cnt = 0;
    int valid_cnt = 0;
    int ce0, done0, valid0;

    logic [7:0] pipe [0:5];

    vdp18_vram_seq #(.RD_LAT(RD_LAT), .AW(AW)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .clk_en_acc_i  (clk_en_acc_i),
        .access_type_i (access_type_i),
        .disp_addr_i   (disp_addr_i),
        .cpu_wr_req_i  (cpu_wr_req_i),
        .cpu_rd_req_i  (cpu_rd_req_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_wdata_i   (cpu_wdata_i),
        .cpu_busy_o    (cpu_busy_o),
        .cpu_done_o    (cpu_done_o),
        .cpu_rdata_o   (cpu_rdata_o),
        .vram_a_o      (vram_a_o),
        .vram_ce_o     (vram_ce_o),
        .vram_we_o     (vram_we_o),
        .vram_d_o      (vram_d_o),
        .vram_d_i      (vram_d_i),
        .disp_data_o   (disp_data_o),
        .disp_valid_o  (disp_valid_o),
        .disp_type_o   (disp_type_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] vram_byte(input logic [AW-1:0] a);
        if (a == 14'h1A05)      return 8'h5A;
        else if (a == 14'h3FFF) return 8'hA7;
        else                    return a[7:0] ^ 8'h3C;
    endfunction

    // Read data is valid only exactly RD_LAT cycles after the enable pulse
    always @(posedge clk_i) begin
        pipe[0] <= (vram_ce_o && !vram_we_o) ? vram_byte(vram_a_o) : 8'hEE;
        for (int k = 1; k < 6; k++) pipe[k] <= pipe[k-1];
    end
    assign vram_d_i = pipe[RD_LAT-1];

    always @(posedge clk_i) begin
        if (vram_ce_o)    ce_cnt++;
        if (cpu_done_o)   done_cnt++;
        if (disp_valid_o) valid_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Strobe in the current cycle; returns one cycle later (strobe+1)
    task automatic strobe(input access_t t, input logic [AW-1:0] a);
        clk_en_acc_i  = 1'b1;
        access_type_i = t;
        disp_addr_i   = a;
        tick();
        clk_en_acc_i  = 1'b0;
        access_type_i = AC_NONE;
    endtask

    initial begin
        for (int k = 0; k < 6; k++) pipe[k] = 8'hEE;
        reset_i       = 1'b1;
        clk_en_acc_i  = 1'b0;
        access_type_i = AC_NONE;
        disp_addr_i   = '0;
        cpu_wr_req_i  = 1'b0;
        cpu_rd_req_i  = 1'b0;
        cpu_addr_i    = '0;
        cpu_wdata_i   = '0;
        ticks(3);
        check("rst_ce", 32'(vram_ce_o), 32'd0);
        check("rst_a", 32'(vram_a_o), 32'd0);
        check("rst_busy", 32'(cpu_busy_o), 32'd0);
        check("rst_valid", 32'(disp_valid_o), 32'd0);
        check("rst_type", 32'(disp_type_o), 32'(AC_NONE));
        check("rst_rdata", 32'(cpu_rdata_o), 32'd0);
        reset_i = 1'b0;
        ticks(2);

        // Display fetch
        strobe(AC_PGT, 14'h1A05);
        check("pgt_ce", 32'(vram_ce_o), 32'd1);
        check("pgt_a", 32'(vram_a_o), 32'h1A05);
        check("pgt_we", 32'(vram_we_o), 32'd0);
        tick();
        check("pgt_ce_pulse", 32'(vram_ce_o), 32'd0);
        tick();
        check("pgt_early_valid", 32'(disp_valid_o), 32'd0);
        tick();
        check("pgt_valid", 32'(disp_valid_o), 32'd1);
        check("pgt_data", 32'(disp_data_o), 32'h5A);
        check("pgt_type", 32'(disp_type_o), 32'(AC_PGT));
        tick();
        check("pgt_valid_pulse", 32'(disp_valid_o), 32'd0);
        ticks(3);

        // CPU write
        cpu_wr_req_i = 1'b1; cpu_addr_i = 14'h0800; cpu_wdata_i = 8'hC3;
        tick();
        cpu_wr_req_i = 1'b0;
        check("wr_busy", 32'(cpu_busy_o), 32'd1);
        ticks(7);
        strobe(AC_CPU, 14'h1234);
        check("wr_ce", 32'(vram_ce_o), 32'd1);
        check("wr_we", 32'(vram_we_o), 32'd1);
        check("wr_a", 32'(vram_a_o), 32'h0800);
        check("wr_d", 32'(vram_d_o), 32'hC3);
        tick();
        check("wr_done", 32'(cpu_done_o), 32'd1);
        check("wr_busy_done", 32'(cpu_busy_o), 32'd1);
        check("wr_we_off", 32'(vram_we_o), 32'd0);
        tick();
        check("wr_done_pulse", 32'(cpu_done_o), 32'd0);
        check("wr_busy_clr", 32'(cpu_busy_o), 32'd0);
        ticks(5);

        // CPU read held off by display slots
        done0 = done_cnt;
        cpu_rd_req_i = 1'b1; cpu_addr_i = 14'h3FFF;
        tick();
        cpu_rd_req_i = 1'b0;
        ticks(2);
        strobe(AC_PNT, 14'h0100);
        check("pnt_a", 32'(vram_a_o), 32'h0100);
        check("pnt_we", 32'(vram_we_o), 32'd0);
        ticks(7);
        strobe(AC_PCT, 14'h2040);
        check("pct_a", 32'(vram_a_o), 32'h2040);
        ticks(3);
        check("pct_data", 32'(disp_data_o), 32'h7C);
        check("pct_type", 32'(disp_type_o), 32'(AC_PCT));
        check("rd_not_yet", 32'(done_cnt - done0), 32'd0);
        ticks(4);
        strobe(AC_CPU, 14'h0000);
        check("rd_a", 32'(vram_a_o), 32'h3FFF);
        check("rd_we", 32'(vram_we_o), 32'd0);
        ticks(3);
        check("rd_done", 32'(cpu_done_o), 32'd1);
        check("rd_data", 32'(cpu_rdata_o), 32'hA7);
        tick();
        check("rd_busy_clr", 32'(cpu_busy_o), 32'd0);
        check("rd_done_once", 32'(done_cnt - done0), 32'd1);
        ticks(3);

        // Request coincident with AC_CPU strobe, then a dropped request while busy
        done0 = done_cnt;
        cpu_wr_req_i = 1'b1; cpu_addr_i = 14'h0555; cpu_wdata_i = 8'h99;
        strobe(AC_CPU, 14'h0000);
        cpu_wr_req_i = 1'b0;
        check("same_ce", 32'(vram_ce_o), 32'd0);
        check("same_busy", 32'(cpu_busy_o), 32'd1);
        cpu_rd_req_i = 1'b1; cpu_addr_i = 14'h0001;
        tick();
        cpu_rd_req_i = 1'b0;
        ticks(6);
        strobe(AC_CPU, 14'h0000);
        check("same_a", 32'(vram_a_o), 32'h0555);
        check("same_we", 32'(vram_we_o), 32'd1);
        check("same_d", 32'(vram_d_o), 32'h99);
        ticks(2);
        check("same_busy_clr", 32'(cpu_busy_o), 32'd0);
        ticks(5);
        check("drop_done_once", 32'(done_cnt - done0), 32'd1);

        // Idle slots: AC_CPU without request, then AC_NONE
        ce0 = ce_cnt; done0 = done_cnt; valid0 = valid_cnt;
        strobe(AC_CPU, 14'h0000);
        ticks(7);
        strobe(AC_NONE, 14'h1A05);
        ticks(7);
        check("idle_ce", 32'(ce_cnt - ce0), 32'd0);
        check("idle_pulses", 32'((done_cnt - done0) + (valid_cnt - valid0)), 32'd0);

        // Simultaneous read and write request: write wins
        cpu_wr_req_i = 1'b1; cpu_rd_req_i = 1'b1;
        cpu_addr_i = 14'h0A0A; cpu_wdata_i = 8'h3E;
        tick();
        cpu_wr_req_i = 1'b0; cpu_rd_req_i = 1'b0;
        ticks(7);
        strobe(AC_CPU, 14'h0000);
        check("both_we", 32'(vram_we_o), 32'd1);
        check("both_a", 32'(vram_a_o), 32'h0A0A);
        check("both_d", 32'(vram_d_o), 32'h3E);
        ticks(7);

        // Reset in WAIT aborts the fetch
        valid0 = valid_cnt;
        strobe(AC_SATX, 14'h0123);
        tick();
        reset_i = 1'b1;
        #1;
        check("arst_a", 32'(vram_a_o), 32'd0);
        check("arst_data", 32'(disp_data_o), 32'd0);
        check("arst_type", 32'(disp_type_o), 32'(AC_NONE));
        check("arst_d", 32'(vram_d_o), 32'd0);
        ticks(2);
        reset_i = 1'b0;
        ticks(5);
        check("arst_no_valid", 32'(valid_cnt - valid0), 32'd0);
        strobe(AC_SATY, 14'h1A05);
        check("saty_ce", 32'(vram_ce_o), 32'd1);
        ticks(3);
        check("saty_valid", 32'(disp_valid_o), 32'd1);
        check("saty_data", 32'(disp_data_o), 32'h5A);
        check("saty_type", 32'(disp_type_o), 32'(AC_SATY));
        ticks(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
